// File: rtl/bin_bcd_scanner.sv
// Binary-to-BCD converter (sequential double-dabble) feeding a multiplexed
// common-anode display scanner with optional leading-zero blanking.
module bin_bcd_scanner #(
  parameter int unsigned BIN_W    = 14,
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd_all,
  output logic [3:0]            bcd_out,
  output logic [DIGITS-1:0]     an_n
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(BIN_W + 1);
  localparam int unsigned PreW = $clog2(SCAN_DIV);
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [63:0]     MaxVal  = 64'(10 ** DIGITS - 1);
  localparam logic [CntW-1:0] CntInit = CntW'(BIN_W);
  localparam logic [PreW-1:0] PreLast = PreW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DIGITS - 1);

  typedef enum logic [1:0] {StIdle, StShift, StLatch} state_e;

  state_e            state_q;
  logic [BIN_W-1:0]  shift_q;
  logic [BcdW-1:0]   scratch_q;
  logic [BcdW-1:0]   scratch_adj;
  logic [CntW-1:0]   cnt_q;
  logic              ovf_pend_q;
  logic              busy_q;
  logic              done_q;
  logic              ovf_q;
  logic [BcdW-1:0]   bcd_q;

  logic [PreW-1:0]   presc_q;
  logic [IdxW-1:0]   idx_q;
  logic [IdxW-1:0]   idx_nxt;
  logic [DIGITS-1:0] an_q;
  logic [DIGITS-1:0] an_nxt;
  logic [3:0]        code_q;
  logic [3:0]        code_nxt;
  logic              zero_above;

  // Add-3 correction applied to every nibble before each shift.
  always_comb begin
    scratch_adj = scratch_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (scratch_q[4*k +: 4] >= 4'd5) begin
        scratch_adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      bcd_q      <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (load) begin
            shift_q    <= bin_in;
            scratch_q  <= '0;
            cnt_q      <= CntInit;
            ovf_pend_q <= (64'(bin_in) > MaxVal);
            busy_q     <= 1'b1;
            state_q    <= StShift;
          end
        end
        StShift: begin
          // Carry out of the top nibble falls off the left end.
          {scratch_q, shift_q} <= {scratch_adj[BcdW-2:0], shift_q, 1'b0};
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_q <= StLatch;
          end
        end
        StLatch: begin
          bcd_q   <= ovf_pend_q ? '1 : scratch_q;
          ovf_q   <= ovf_pend_q;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Code for the digit that becomes active at the next index advance.
  always_comb begin
    idx_nxt    = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
    zero_above = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if ((k >= int'(idx_nxt)) && (bcd_q[4*k +: 4] != 4'h0)) begin
        zero_above = 1'b0;
      end
    end
    if (blank_lz && (idx_nxt != '0) && zero_above) begin
      code_nxt = 4'hF;
    end else begin
      code_nxt = bcd_q[{idx_nxt, 2'b00} +: 4];
    end
    an_nxt = ~(DIGITS'(1) << idx_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
      an_q    <= ~DIGITS'(1);
      code_q  <= 4'h0;
    end else if (presc_q == PreLast) begin
      presc_q <= '0;
      idx_q   <= idx_nxt;
      an_q    <= an_nxt;
      code_q  <= code_nxt;
    end else begin
      presc_q <= presc_q + PreW'(1);
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;
  assign bcd_all  = bcd_q;
  assign bcd_out  = code_q;
  assign an_n     = an_q;

endmodule

// File: tb/tb_bin_bcd_scanner.sv
// Directed bench for bin_bcd_scanner with a short scan period.
module tb_bin_bcd_scanner;

  logic        clk;
  logic        rst_n;
  logic [13:0] bin_in;
  logic        load;
  logic        blank_lz;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [15:0] bcd_all;
  logic [3:0]  bcd_out;
  logic [3:0]  an_n;

  int n_tests = 0;
  int n_fail  = 0;

  bin_bcd_scanner #(
    .BIN_W   (14),
    .DIGITS  (4),
    .SCAN_DIV(4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bin_in  (bin_in),
    .load    (load),
    .blank_lz(blank_lz),
    .busy    (busy),
    .done    (done),
    .overflow(overflow),
    .bcd_all (bcd_all),
    .bcd_out (bcd_out),
    .an_n    (an_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a conversion; optionally inject a load at cycle inj or keep load high.
  task automatic conv(input logic [13:0] v, input int inj, input bit hold,
                      output int n, output int nbusy, output bit early);
    logic [15:0] old;
    old    = bcd_all;
    bin_in = v;
    load   = 1'b1;
    n      = 0;
    nbusy  = 0;
    early  = 1'b0;
    do begin
      tick();
      n++;
      if (!hold) load = 1'b0;
      if (n == inj) begin
        bin_in = 14'd999;
        load   = 1'b1;
      end
      if (busy) nbusy++;
      if (!done && (bcd_all !== old)) early = 1'b1;
    end while (!done && n < 40);
  endtask

  function automatic int idx_of(input logic [3:0] a);
    for (int i = 0; i < 4; i++) if (a[i] == 1'b0) return i;
    return 0;
  endfunction

  // Wait for the next digit advance, then check one full scan round.
  task automatic scan(input logic [15:0] expn, input string tag);
    logic [3:0] prev;
    int         start;
    int         w;
    int         i;
    bit         moved;
    prev  = an_n;
    moved = 1'b0;
    w     = 0;
    while (!moved && w < 8) begin
      tick();
      w++;
      if (an_n !== prev) moved = 1'b1;
    end
    check({tag, "_adv"}, 32'(moved), 32'd1);
    start = idx_of(an_n);
    for (int d = 0; d < 4; d++) begin
      i = (start + d) % 4;
      for (int h = 0; h < 4; h++) begin
        check({tag, "_scan"}, {24'd0, an_n, bcd_out}, {24'd0, ~(4'b0001 << i), expn[i*4 +: 4]});
        tick();
      end
    end
  endtask

  int n;
  int nb;
  bit early;
  int ndone;

  initial begin
    rst_n    = 1'b0;
    load     = 1'b0;
    blank_lz = 1'b0;
    bin_in   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) tick();

    // Asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    check("rst_an", 32'(an_n), 32'b1110);
    check("rst_bcd_out", 32'(bcd_out), 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd_all", 32'(bcd_all), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic conversion and scan order
    conv(14'd1234, 0, 1'b0, n, nb, early);
    check("c1234_lat", 32'(n), 32'd16);
    check("c1234_busy", 32'(nb), 32'd15);
    check("c1234_early", 32'(early), 32'd0);
    check("c1234_val", 32'(bcd_all), 32'h1234);
    check("c1234_ovf", 32'(overflow), 32'd0);
    tick();
    check("c1234_done1", 32'(done), 32'd0);
    scan(16'h1234, "s1234");

    // Range limits
    conv(14'd9999, 0, 1'b0, n, nb, early);
    check("c9999_val", 32'(bcd_all), 32'h9999);
    check("c9999_ovf", 32'(overflow), 32'd0);
    conv(14'd10000, 0, 1'b0, n, nb, early);
    check("c10000_val", 32'(bcd_all), 32'hFFFF);
    check("c10000_ovf", 32'(overflow), 32'd1);
    scan(16'hFFFF, "s10000");
    check("ovf_held", 32'(overflow), 32'd1);
    conv(14'd0, 0, 1'b0, n, nb, early);
    check("c0_ovf", 32'(overflow), 32'd0);
    check("c0_val", 32'(bcd_all), 32'h0000);

    // Leading-zero blanking
    blank_lz = 1'b1;
    conv(14'd7, 0, 1'b0, n, nb, early);
    scan(16'hFFF7, "lz7");
    conv(14'd0, 0, 1'b0, n, nb, early);
    scan(16'hFFF0, "lz0");
    conv(14'd1000, 0, 1'b0, n, nb, early);
    scan(16'h1000, "lz1000");
    blank_lz = 1'b0;
    conv(14'd7, 0, 1'b0, n, nb, early);
    scan(16'h0007, "nolz7");

    // Load while busy ignored; load held through done accepted
    conv(14'd567, 5, 1'b0, n, nb, early);
    check("ign_lat", 32'(n), 32'd16);
    check("ign_val", 32'(bcd_all), 32'h0567);
    check("ign_early", 32'(early), 32'd0);
    conv(14'd321, 0, 1'b1, n, nb, early);
    check("hold1_lat", 32'(n), 32'd16);
    check("hold1_val", 32'(bcd_all), 32'h0321);
    conv(14'd4000, 0, 1'b0, n, nb, early);
    check("hold2_lat", 32'(n), 32'd16);
    check("hold2_early", 32'(early), 32'd0);
    check("hold2_val", 32'(bcd_all), 32'h4000);

    // Reset in the middle of a conversion
    bin_in = 14'd4321;
    load   = 1'b1;
    tick();
    load = 1'b0;
    repeat (7) tick();
    check("mid_busy_pre", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_bcd_all", 32'(bcd_all), 32'h0);
    check("mid_an", 32'(an_n), 32'b1110);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done) ndone++;
    end
    check("mid_nodone", 32'(ndone), 32'd0);
    check("mid_val_kept", 32'(bcd_all), 32'h0);
    conv(14'd42, 0, 1'b0, n, nb, early);
    check("c42_lat", 32'(n), 32'd16);
    check("c42_val", 32'(bcd_all), 32'h0042);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
